// File: rtl/rf_read_arbiter.sv
// Round-robin arbiter sharing one register-file read port among NREQ requesters.
// Grant and mux select are registered; read data returns to the winner one cycle later.
module rf_read_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   addr,
  output logic [NREQ-1:0]      gnt,
  output logic [AW-1:0]        rf_sel,
  input  logic [DW-1:0]        rf_data,
  output logic [DW-1:0]        rdata,
  output logic [NREQ-1:0]      rvalid
);

  localparam int unsigned PtrW = $clog2(NREQ);
  localparam logic [PtrW:0]   NreqW   = NREQ[PtrW:0];
  localparam logic [PtrW-1:0] LastIdx = PtrW'(NREQ - 1);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [AW-1:0]     rf_sel_q, rf_sel_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic [NREQ-1:0]   rvalid_q, rvalid_d;

  logic [NREQ-1:0]   eligible;
  logic [2*NREQ-1:0] elig_dbl;
  logic [NREQ-1:0]   elig_rot;
  logic [PtrW-1:0]   off;
  logic [PtrW:0]     idx_sum;
  logic [PtrW-1:0]   win_idx;
  logic              win;

  // Rotate the eligible vector so bit 0 is the pointer position, then take the
  // lowest set bit; mapping back needs a modulo-NREQ add.
  always_comb begin
    eligible = req & ~gnt_q;
    elig_dbl = {eligible, eligible};
    elig_rot = elig_dbl[ptr_q +: NREQ];
    win      = 1'b0;
    off      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (elig_rot[i] && !win) begin
        win = 1'b1;
        off = PtrW'(i);
      end
    end
    idx_sum = {1'b0, ptr_q} + {1'b0, off};
    if (idx_sum >= NreqW) begin
      idx_sum = idx_sum - NreqW;
    end
    win_idx = idx_sum[PtrW-1:0];
  end

  always_comb begin
    state_d  = win ? StBusy : StIdle;
    gnt_d    = '0;
    rf_sel_d = rf_sel_q;
    ptr_d    = ptr_q;
    rdata_d  = rdata_q;
    rvalid_d = '0;
    if (win) begin
      gnt_d[win_idx] = 1'b1;
      rf_sel_d       = addr[int'(win_idx) * AW +: AW];
      ptr_d          = (win_idx == LastIdx) ? '0 : win_idx + 1'b1;
    end
    if (state_q == StBusy) begin
      rdata_d  = rf_data;
      rvalid_d = gnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      gnt_q    <= '0;
      rf_sel_q <= '0;
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      rf_sel_q <= rf_sel_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign gnt    = gnt_q;
  assign rf_sel = rf_sel_q;
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Bench for rf_read_arbiter: reference arbiter model plus a return-data scoreboard,
// directed scenarios followed by a random phase.
module tb_rf_read_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 5;
  localparam int DW   = 64;

  logic                clk;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [NREQ*AW-1:0]  addr;
  logic [NREQ-1:0]     gnt;
  logic [AW-1:0]       rf_sel;
  logic [DW-1:0]       rf_data;
  logic [DW-1:0]       rdata;
  logic [NREQ-1:0]     rvalid;

  rf_read_arbiter #(
    .NREQ(NREQ),
    .AW  (AW),
    .DW  (DW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .addr   (addr),
    .gnt    (gnt),
    .rf_sel (rf_sel),
    .rf_data(rf_data),
    .rdata  (rdata),
    .rvalid (rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rf_model(input logic [AW-1:0] a);
    return {16'hA5A5, 43'h0, a};
  endfunction

  assign rf_data = rf_model(rf_sel);

  typedef struct {
    int              due;
    logic [NREQ-1:0] g;
    logic [DW-1:0]   d;
  } ret_t;

  ret_t            sb_q[$];
  int              checks;
  int              failures;
  int              cyc;
  logic [NREQ-1:0] m_gnt;
  logic [AW-1:0]   m_sel;
  int              m_ptr;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_addr(input int k, input logic [AW-1:0] a);
    addr[k*AW +: AW] = a;
  endtask

  // Advance one clock: update the model from current inputs, then compare.
  task automatic tick();
    logic [NREQ-1:0] elig;
    int              w;
    ret_t            e;
    if (reset) begin
      m_gnt = '0;
      m_sel = '0;
      m_ptr = 0;
      sb_q.delete();
    end else begin
      elig = req & ~m_gnt;
      w    = -1;
      for (int i = 0; i < NREQ; i++) begin
        int k;
        k = (m_ptr + i) % NREQ;
        if (w < 0 && elig[k]) w = k;
      end
      if (w >= 0) begin
        m_gnt    = '0;
        m_gnt[w] = 1'b1;
        m_sel    = addr[w*AW +: AW];
        m_ptr    = (w + 1) % NREQ;
        e.due    = cyc + 2;
        e.g      = m_gnt;
        e.d      = rf_model(m_sel);
        sb_q.push_back(e);
      end else begin
        m_gnt = '0;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    check_val("gnt", 64'(gnt), 64'(m_gnt));
    check_val("rf_sel", 64'(rf_sel), 64'(m_sel));
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      e = sb_q.pop_front();
      check_val("rvalid", 64'(rvalid), 64'(e.g));
      check_val("rdata", rdata, e.d);
    end else begin
      check_val("rvalid_idle", 64'(rvalid), 64'h0);
    end
  endtask

  initial begin
    logic [NREQ-1:0] exp_seq [5];
    int              g3_cnt;
    logic            g3_prev;
    int              g3_back2back;

    checks   = 0;
    failures = 0;
    cyc      = 0;
    m_gnt    = '0;
    m_sel    = '0;
    m_ptr    = 0;
    exp_seq  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset with all requesters active
    reset = 1'b1;
    req   = 4'b1111;
    addr  = '0;
    set_addr(0, 5'd3);
    set_addr(1, 5'd7);
    set_addr(2, 5'd11);
    set_addr(3, 5'd15);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_val("rst_gnt", 64'(gnt), 64'h0);
      check_val("rst_rvalid", 64'(rvalid), 64'h0);
      check_val("rst_rf_sel", 64'(rf_sel), 64'h0);
      check_val("rst_rdata", rdata, 64'h0);
    end
    reset = 1'b0;

    // Full contention: round robin with no idle cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("rr_seq", 64'(gnt), 64'(exp_seq[i]));
      if (i > 0) check_val("rr_rvalid", 64'(rvalid), 64'(exp_seq[i-1]));
    end
    req = '0;
    repeat (3) tick();

    // Single read, address changed after the win
    req = 4'b0100;
    set_addr(2, 5'd17);
    tick();
    check_val("single_gnt", 64'(gnt), 64'h4);
    check_val("single_sel", 64'(rf_sel), 64'd17);
    req = '0;
    set_addr(2, 5'd5);
    tick();
    check_val("single_rvalid", 64'(rvalid), 64'h4);
    check_val("single_rdata", rdata, 64'hA5A5_0000_0000_0011);
    tick();

    // Address 31 passes through
    req = 4'b0010;
    set_addr(1, 5'd31);
    tick();
    check_val("a31_sel", 64'(rf_sel), 64'd31);
    req = '0;
    tick();
    check_val("a31_rdata", rdata, 64'hA5A5_0000_0000_001F);
    check_val("a31_rvalid", 64'(rvalid), 64'h2);

    // Lone requester 3 is masked every other cycle
    req          = 4'b1000;
    g3_cnt       = 0;
    g3_prev      = 1'b0;
    g3_back2back = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (gnt[3]) g3_cnt++;
      if (gnt[3] && g3_prev) g3_back2back++;
      g3_prev = gnt[3];
    end
    check_val("mask_cnt", 64'(g3_cnt), 64'd3);
    check_val("mask_b2b", 64'(g3_back2back), 64'd0);
    req = '0;
    repeat (2) tick();
    req = 4'b1001;
    tick();
    check_val("wrap_gnt", 64'(gnt), 64'h1);
    tick();
    check_val("wrap_next", 64'(gnt), 64'h8);
    req = '0;
    repeat (2) tick();

    // Reset with a read in flight
    req = 4'b0010;
    tick();
    check_val("inflt_gnt", 64'(gnt), 64'h2);
    reset = 1'b1;
    req   = '0;
    tick();
    check_val("mrst_gnt", 64'(gnt), 64'h0);
    check_val("mrst_rvalid", 64'(rvalid), 64'h0);
    check_val("mrst_sel", 64'(rf_sel), 64'h0);
    check_val("mrst_rdata", rdata, 64'h0);
    reset = 1'b0;
    tick();
    check_val("post_rst_rvalid", 64'(rvalid), 64'h0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      req  = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      addr = (NREQ*AW)'({$urandom, $urandom});
      tick();
    end
    req = '0;
    repeat (3) tick();
    check_val("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
